// File: rtl/alu_hilo_issue_pkg.sv
// Shared definitions for the HI/LO issue block: ALU function codes,
// the clock/reset control bundle and the issue FSM state encoding.
package alu_hilo_issue_pkg;

    localparam int ALU_FUNC_W = 4;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_MULT = 4'h8,
        ALU_MULU = 4'h9,
        ALU_DIV  = 4'hA,
        ALU_DIVU = 4'hB,
        ALU_MFHI = 4'hC,
        ALU_MFLO = 4'hD,
        ALU_MTHI = 4'hE,
        ALU_MTLO = 4'hF
    } alu_func_e;

    // Single clock plus active-low synchronous reset.
    typedef struct packed {
        logic clock;
        logic reset_n;
    } util_control_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_e;

    function automatic logic is_hilo_func(input alu_func_e f);
        return f inside {ALU_MULT, ALU_MULU, ALU_DIV, ALU_DIVU,
                         ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO};
    endfunction

    function automatic logic is_mul_func(input alu_func_e f);
        return f inside {ALU_MULT, ALU_MULU};
    endfunction

    function automatic logic is_div_func(input alu_func_e f);
        return f inside {ALU_DIV, ALU_DIVU};
    endfunction

    function automatic logic is_mt_func(input alu_func_e f);
        return f inside {ALU_MTHI, ALU_MTLO};
    endfunction

endpackage

// File: rtl/alu_hilo_issue_if.sv
// Execute-stage instruction bus and HI/LO launch bus of the issue block.
// Handshake: an instruction is taken on a cycle where in_valid and in_ready
// are both high; stall = in_valid & ~in_ready. hilo_start is a one-cycle
// launch with no back-pressure from the HI/LO unit.
interface alu_hilo_issue_if #(
    parameter int DATA_W = 32
);
    import alu_hilo_issue_pkg::*;

    logic              in_valid;
    alu_func_e         in_func;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic              in_ready;
    logic              stall;
    logic              hilo_start;
    alu_func_e         hilo_func;
    logic [DATA_W-1:0] hilo_data1;
    logic [DATA_W-1:0] hilo_data2;
    logic              busy;
    logic              err;
    hilo_state_e       state_dbg;

    modport master (
        output in_valid, in_func, in_data1, in_data2,
        input  in_ready, stall, hilo_start, hilo_func, hilo_data1, hilo_data2,
        input  busy, err, state_dbg
    );

    modport slave (
        input  in_valid, in_func, in_data1, in_data2,
        output in_ready, stall, hilo_start, hilo_func, hilo_data1, hilo_data2,
        output busy, err, state_dbg
    );

endinterface

// File: rtl/alu_hilo_issue_timer.sv
// Remaining-cycle down-counter: load has priority over decrement and the
// count saturates at zero.
module alu_hilo_issue_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] value_q, value_d;

    // Next count: load, decrement or hold.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/alu_hilo_issue.sv
// HI/LO issue control: launches multiply/divide/move-to operations to the
// HI/LO unit and stalls HI/LO-class instructions while a result is pending.
// Build option: define ALU_HILO_ISSUE_DIV_EN to launch Div/Divu; without it
// divides are accepted and flagged with a one-cycle err pulse.
module alu_hilo_issue
    import alu_hilo_issue_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DELAY     = 4,
    parameter int DIV_DELAY = 8
) (
    input util_control_t         ctrl,
    alu_hilo_issue_if.slave      bus
);
    localparam int MAX_LAT = (DELAY > DIV_DELAY) ? DELAY : DIV_DELAY;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    logic clk, rst_n;
    assign clk   = ctrl.clock;
    assign rst_n = ctrl.reset_n;

    hilo_state_e       state_q, state_d;
    alu_func_e         func_q, func_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt_val;
    logic             start, ready, busy_o, err_o;

    alu_hilo_issue_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_load_val),
        .dec        (cnt_dec),
        .value      (cnt_val),
        .zero       (cnt_zero)
    );

    // Next state, launch decision and held launch operands.
    always_comb begin
        state_d      = state_q;
        func_d       = func_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        start        = 1'b0;
        ready        = 1'b1;
        busy_o       = 1'b0;
        err_o        = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mul_func(bus.in_func)) begin
                            start        = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(DELAY - 1);
                            state_d      = (DELAY > 1) ? BUSY : IDLE;
                        end else if (is_div_func(bus.in_func)) begin
`ifdef ALU_HILO_ISSUE_DIV_EN
                            start        = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(DIV_DELAY - 1);
                            state_d      = (DIV_DELAY > 1) ? BUSY : IDLE;
`else
                            err_o        = 1'b1;
`endif
                        end else if (is_mt_func(bus.in_func)) begin
                            start = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    busy_o  = 1'b1;
                    ready   = !(bus.in_valid && is_hilo_func(bus.in_func));
                    cnt_dec = 1'b1;
                    // Leave BUSY on the cycle the count reaches zero.
                    if (cnt_zero || (cnt_val == CNT_W'(1))) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (start) begin
            func_d  = bus.in_func;
            data1_d = bus.in_data1;
            data2_d = bus.in_data2;
        end
    end

    // State and last-launched operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            func_q  <= alu_func_e'('0);
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.stall      = bus.in_valid & ~ready;
    assign bus.hilo_start = start;
    assign bus.busy       = busy_o;
    assign bus.err        = err_o;
    assign bus.state_dbg  = state_q;
    // Launch operands pass through on a launch, otherwise hold; forced to
    // zero while reset is asserted.
    assign bus.hilo_func  = !rst_n ? alu_func_e'('0) : (start ? bus.in_func : func_q);
    assign bus.hilo_data1 = !rst_n ? '0 : (start ? bus.in_data1 : data1_q);
    assign bus.hilo_data2 = !rst_n ? '0 : (start ? bus.in_data2 : data2_q);

endmodule

// File: tb/tb_alu_hilo_issue.sv
// Directed bench for alu_hilo_issue (DATA_W=4, DELAY=3, DIV_DELAY=5).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge of the same cycle.
module tb_alu_hilo_issue;
    import alu_hilo_issue_pkg::*;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    util_control_t ctrl;
    int            checks   = 0;
    int            failures = 0;

    assign ctrl = '{clock: clk, reset_n: rst_n};

    alu_hilo_issue_if #(.DATA_W(4)) bus ();

    alu_hilo_issue #(.DATA_W(4), .DELAY(3), .DIV_DELAY(5)) dut (
        .ctrl (ctrl),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then move to that cycle's falling edge.
    task automatic cycle(input logic rst, input logic v, input alu_func_e f,
                         input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        rst_n        = rst;
        bus.in_valid = v;
        bus.in_func  = f;
        bus.in_data1 = a;
        bus.in_data2 = b;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b1, 1'b0, ALU_ADD, 4'h0, 4'h0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_func  = ALU_ADD;
        bus.in_data1 = '0;
        bus.in_data2 = '0;

        // Reset
        cycle(1'b0, 1'b0, ALU_ADD, 4'h0, 4'h0);
        cycle(1'b0, 1'b1, ALU_MULT, 4'h3, 4'h4);
        chk("rst_hilo_start", bus.hilo_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_hilo_data1", bus.hilo_data1, 0);
        chk("rst_hilo_func", bus.hilo_func, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall", bus.stall, 0);
        idle_cycle();
        chk("idle_busy", bus.busy, 0);

        // Mulu then Mfhi stalls two cycles
        cycle(1'b1, 1'b1, ALU_MULU, 4'hA, 4'hA);
        chk("mulu_start", bus.hilo_start, 1);
        chk("mulu_d1", bus.hilo_data1, 4'hA);
        chk("mulu_d2", bus.hilo_data2, 4'hA);
        chk("mulu_func", bus.hilo_func, ALU_MULU);
        chk("mulu_ready", bus.in_ready, 1);
        cycle(1'b1, 1'b1, ALU_MFHI, 4'h0, 4'h0);
        chk("mfhi_c1_stall", bus.stall, 1);
        chk("mfhi_c1_ready", bus.in_ready, 0);
        chk("mfhi_c1_busy", bus.busy, 1);
        chk("mfhi_c1_start", bus.hilo_start, 0);
        chk("mfhi_c1_hold_d1", bus.hilo_data1, 4'hA);
        chk("mfhi_c1_hold_func", bus.hilo_func, ALU_MULU);
        cycle(1'b1, 1'b1, ALU_MFHI, 4'h0, 4'h0);
        chk("mfhi_c2_stall", bus.stall, 1);
        chk("mfhi_c2_busy", bus.busy, 1);
        cycle(1'b1, 1'b1, ALU_MFHI, 4'h0, 4'h0);
        chk("mfhi_c3_ready", bus.in_ready, 1);
        chk("mfhi_c3_stall", bus.stall, 0);
        chk("mfhi_c3_busy", bus.busy, 0);
        chk("mfhi_c3_start", bus.hilo_start, 0);

        // Mult then Add flows past a busy unit
        cycle(1'b1, 1'b1, ALU_MULT, 4'h3, 4'h2);
        chk("mult_start", bus.hilo_start, 1);
        cycle(1'b1, 1'b1, ALU_ADD, 4'h1, 4'h1);
        chk("add_ready", bus.in_ready, 1);
        chk("add_stall", bus.stall, 0);
        chk("add_busy", bus.busy, 1);
        chk("add_start", bus.hilo_start, 0);
        idle_cycle();
        chk("mult_c2_busy", bus.busy, 1);
        idle_cycle();
        chk("mult_c3_busy", bus.busy, 0);

        // Mthi launches without BUSY
        cycle(1'b1, 1'b1, ALU_MTHI, 4'h5, 4'h0);
        chk("mthi_start", bus.hilo_start, 1);
        chk("mthi_d1", bus.hilo_data1, 4'h5);
        chk("mthi_busy", bus.busy, 0);
        idle_cycle();
        chk("mthi_next_start", bus.hilo_start, 0);
        chk("mthi_next_busy", bus.busy, 0);
        chk("mthi_hold_d1", bus.hilo_data1, 4'h5);
        cycle(1'b1, 1'b1, ALU_SUB, 4'h7, 4'h1);
        chk("sub_ready", bus.in_ready, 1);
        chk("sub_start", bus.hilo_start, 0);
        chk("sub_hold_func", bus.hilo_func, ALU_MTHI);

        // Reset mid-BUSY abandons the multiply
        cycle(1'b1, 1'b1, ALU_MULT, 4'h7, 4'h7);
        chk("mult_r_start", bus.hilo_start, 1);
        cycle(1'b0, 1'b0, ALU_ADD, 4'h0, 4'h0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_d1", bus.hilo_data1, 0);
        cycle(1'b1, 1'b1, ALU_MFLO, 4'h0, 4'h0);
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_stall", bus.stall, 0);
        chk("postrst_start", bus.hilo_start, 0);
        chk("postrst_ready", bus.in_ready, 1);
        chk("postrst_hold_d1", bus.hilo_data1, 0);

        // Divu
        cycle(1'b1, 1'b1, ALU_DIVU, 4'hF, 4'h3);
`ifdef ALU_HILO_ISSUE_DIV_EN
        chk("divu_start", bus.hilo_start, 1);
        chk("divu_err", bus.err, 0);
        chk("divu_d2", bus.hilo_data2, 4'h3);
        for (int i = 1; i <= 4; i++) begin
            idle_cycle();
            chk("divu_busy", bus.busy, 1);
        end
        idle_cycle();
        chk("divu_done_busy", bus.busy, 0);
        chk("divu_hold_func", bus.hilo_func, ALU_DIVU);
        // Divide by zero launches normally
        cycle(1'b1, 1'b1, ALU_DIV, 4'h9, 4'h0);
        chk("div0_start", bus.hilo_start, 1);
        chk("div0_d2", bus.hilo_data2, 4'h0);
        for (int i = 1; i <= 4; i++) idle_cycle();
        idle_cycle();
        chk("div0_done_busy", bus.busy, 0);
`else
        chk("divu_err", bus.err, 1);
        chk("divu_start", bus.hilo_start, 0);
        chk("divu_ready", bus.in_ready, 1);
        chk("divu_busy", bus.busy, 0);
        idle_cycle();
        chk("divu_err_once", bus.err, 0);
        chk("divu_next_busy", bus.busy, 0);
        chk("divu_hold_d2", bus.hilo_data2, 0);
        cycle(1'b1, 1'b1, ALU_DIV, 4'h9, 4'h0);
        chk("div0_err", bus.err, 1);
        chk("div0_start", bus.hilo_start, 0);
`endif

        // Back-to-back multiplies serialise with no gap
        idle_cycle();
        cycle(1'b1, 1'b1, ALU_MULU, 4'h2, 4'h3);
        chk("b2b_first_start", bus.hilo_start, 1);
        cycle(1'b1, 1'b1, ALU_MULT, 4'h4, 4'h5);
        chk("b2b_c1_stall", bus.stall, 1);
        chk("b2b_c1_start", bus.hilo_start, 0);
        cycle(1'b1, 1'b1, ALU_MULT, 4'h4, 4'h5);
        chk("b2b_c2_stall", bus.stall, 1);
        cycle(1'b1, 1'b1, ALU_MULT, 4'h4, 4'h5);
        chk("b2b_c3_start", bus.hilo_start, 1);
        chk("b2b_c3_ready", bus.in_ready, 1);
        chk("b2b_c3_d1", bus.hilo_data1, 4'h4);
        chk("b2b_c3_func", bus.hilo_func, ALU_MULT);
        idle_cycle();
        chk("b2b_c4_busy", bus.busy, 1);
        idle_cycle();
        idle_cycle();
        chk("b2b_c6_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
